// File: rtl/wa_sink_buffer_pkg.sv
// Shared types for the wa sink buffer: write-out entry layout and bus widths.
package lib;
  localparam int WA_ADDR_W = 16;
  localparam int WA_DATA_W = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wa_entry_t;
endpackage

// File: rtl/wa_sink_buffer_if.sv
// wa write-out strobe and backend valid/ready bundle.
interface wa_sink_buffer_if;
  import lib::*;

  logic                 wa_wr_s;
  logic [WA_ADDR_W-1:0] wa_addr;
  logic [WA_DATA_W-1:0] wa_data_wr;
  logic                 bk_valid;
  logic [WA_ADDR_W-1:0] bk_addr;
  logic [WA_DATA_W-1:0] bk_data;
  logic                 bk_ready;

  modport slave (
    input  wa_wr_s, wa_addr, wa_data_wr, bk_ready,
    output bk_valid, bk_addr, bk_data
  );

  modport master (
    output wa_wr_s, wa_addr, wa_data_wr, bk_ready,
    input  bk_valid, bk_addr, bk_data
  );
endinterface

// File: rtl/wa_sink_buffer_fifo_mem.sv
// Entry storage: one sync write port (push or in-place overwrite), one comb read.
module wa_fifo_mem
  import lib::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  wa_entry_t     wr_entry,
  input  logic [AW-1:0] rd_idx,
  output wa_entry_t     rd_entry
);

  wa_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_entry;
  end

  assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/wa_sink_buffer.sv
// FIFO between non-stallable SIF wa writes and a backpressuring backend.
// Define WA_COALESCE_EN to merge same-address writes into the tail entry.
module wa_sink_buffer
  import lib::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  wa_sink_buffer_if.slave  bus,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          pop, push, drop, coal;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_idx;
  logic [AW-1:0] tail_idx;
  wa_entry_t     head;

  assign tail_idx = wr_ptr_q - AW'(1);
  assign pop      = (level_q != '0) && bus.bk_ready;

`ifdef WA_COALESCE_EN
  logic [WA_ADDR_W-1:0] tail_addr_q, tail_addr_d;

  // A lone entry leaving this cycle cannot absorb the write.
  assign coal = bus.wa_wr_s && (level_q != '0)
             && (bus.wa_addr == tail_addr_q)
             && !(pop && level_q == LW'(1));

  always_comb begin
    tail_addr_d = tail_addr_q;
    if (push) tail_addr_d = bus.wa_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) tail_addr_q <= '0;
    else     tail_addr_q <= tail_addr_d;
  end
`else
  assign coal = 1'b0;
`endif

  assign push = bus.wa_wr_s && !coal
             && ((level_q != FULL_LVL) || pop);
  assign drop = bus.wa_wr_s && !coal
             && (level_q == FULL_LVL) && !pop;

  assign mem_wr_en  = push || coal;
  assign mem_wr_idx = coal ? tail_idx : wr_ptr_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // A drop in the clearing cycle restarts the count at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)                 drop_cnt_d = CNT_W'(1);
      else if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  wa_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .wr_en    (mem_wr_en),
    .wr_idx   (mem_wr_idx),
    .wr_entry ('{addr: bus.wa_addr, data: bus.wa_data_wr}),
    .rd_idx   (rd_ptr_q),
    .rd_entry (head)
  );

  assign bus.bk_valid = (level_q != '0);
  assign bus.bk_addr  = bus.bk_valid ? head.addr : '0;
  assign bus.bk_data  = bus.bk_valid ? head.data : '0;
  assign level        = level_q;
  assign full         = (level_q == FULL_LVL);
  assign ovf          = ovf_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_wa_sink_buffer.sv
// Randomized + directed bench for wa_sink_buffer against a queue-based model.
module tb_wa_sink_buffer;
  import lib::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic ovf_clr;
  logic [3:0] level;
  logic full, ovf;
  logic [CNT_W-1:0] drop_cnt;

  wa_sink_buffer_if bus ();

  wa_sink_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .level    (level),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  wa_entry_t q[$];
  logic      m_ovf;
  int        m_drop;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic rdy,
                       input logic clr, input logic r);
    bit pop, coal, drop;
    int sz;
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    sz   = q.size();
    pop  = (sz > 0) && rdy;
    coal = 1'b0;
    drop = 1'b0;
`ifdef WA_COALESCE_EN
    if (wr && sz > 0 && q[sz-1].addr == a && !(pop && sz == 1))
      coal = 1'b1;
`endif
    if (coal) q[sz-1].data = d;
    else begin
      if (pop) void'(q.pop_front());
      if (wr) begin
        if (sz < DEPTH || pop) q.push_back('{addr: a, data: d});
        else drop = 1'b1;
      end
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
  endtask

  task automatic step(input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input logic rdy,
                      input logic clr, input logic r);
    @(negedge clk);
    rst            = r;
    bus.wa_wr_s    = wr;
    bus.wa_addr    = wr ? a : 16'($urandom);
    bus.wa_data_wr = wr ? d : 16'($urandom);
    bus.bk_ready   = rdy;
    ovf_clr        = clr;
    model(wr, a, d, rdy, clr, r);
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("bk_valid", 32'(bus.bk_valid), 32'(q.size() != 0));
    chk("bk_addr", 32'(bus.bk_addr), q.size() ? 32'(q[0].addr) : 32'd0);
    chk("bk_data", 32'(bus.bk_data), q.size() ? 32'(q[0].data) : 32'd0);
    chk("ovf", 32'(m_ovf), 32'(ovf) ^ 32'(ovf) ^ 32'(m_ovf) ) ;
    chk("ovf_flag", 32'(ovf), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0, 16'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ovf_clr = 1'b0;
    bus.wa_wr_s = 1'b0; bus.wa_addr = '0;
    bus.wa_data_wr = '0; bus.bk_ready = 1'b0;
    m_ovf = 1'b0; m_drop = 0;

    step(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_level", 32'(level), 32'd0);

    step(1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("basic_addr", 32'(bus.bk_addr), 32'h0010);
    chk("basic_data", 32'(bus.bk_data), 32'hBEEF);
    idle(1'b1);
    chk("basic_empty", 32'(bus.bk_valid), 32'd0);

    for (int i = 0; i < 8; i++)
      step(1'b1, 16'(16'h20 + i), 16'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("bp_full", 32'(full), 32'd1);
    chk("bp_head", 32'(bus.bk_data), 32'h1);

    for (int i = 0; i < 3; i++)
      step(1'b1, 16'(16'h50 + i), 16'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("ovf_cnt", 32'(drop_cnt), 32'd3);
    chk("ovf_set", 32'(ovf), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(drop_cnt), 32'd0);

    step(1'b1, 16'h0028, 16'h0009, 1'b1, 1'b0, 1'b0);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(bus.bk_data), 32'(i + 2));
      idle(1'b1);
    end

    for (int i = 0; i < 5; i++)
      step(1'b1, 16'(16'h60 + i), 16'(16'h70 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0099, 16'h0099, 1'b0, 1'b0, 1'b1);
    chk("mid_rst", 32'(level), 32'd0);
    step(1'b1, 16'h00AA, 16'h00BB, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head", 32'(bus.bk_addr), 32'h00AA);

    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0040, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0040, 16'h0002, 1'b0, 1'b0, 1'b0);
`ifdef WA_COALESCE_EN
    chk("coal_level", 32'(level), 32'd1);
    chk("coal_head", 32'(bus.bk_data), 32'h2);
`else
    chk("coal_level", 32'(level), 32'd2);
    chk("coal_head", 32'(bus.bk_data), 32'h1);
`endif

    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'(16'h20 + i), 16'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++)
      step(1'b1, 16'(16'h100 + i % 16), 16'(i), 1'b0, 1'b0, 1'b0);
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    step(1'b1, 16'h0111, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_drop", 32'(drop_cnt), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 2) != 0),
           16'(16'h40 + $urandom_range(0, 3)),
           16'($urandom),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
